multicycle_ctrl_hs: RTL

//  Next-generation main controller for the multi-cycle RV32I core. It drives the existing Datapath control set and adds:
//  - a mem_req/mem_ready wait-state handshake, so memory may take variable latency;
//  - a parametrised memory timeout;
//  - a sticky FAULT state for illegal encodings and timeouts.
//  It replaces Controller inside CPU; the datapath port names are unchanged.

---
 rtl/multicycle_ctrl_hs.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle RV32I main controller with mem_req/mem_ready wait states, memory timeout and sticky FAULT.
// Optional perf counters (cycle_cnt, instret_cnt) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_hs #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned WAIT_W      = 8
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opc,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       immSrc,
    output logic             fault
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
        MEM_WR, BRANCH, JAL, JALR_A, JALR_L, LUI, FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              wait_hit;
    logic [2:0]        alu_f3;
    logic              alu_f3_ok;
    logic              unused_f7;

    assign unused_f7 = ^{f7[6], f7[4:0]};

    // Timeout fires only when the limit is reached and memory is still not ready.
    assign wait_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

    // f3 -> ALU op for EXEC_R / EXEC_I; unsupported f3 flags an illegal encoding
    always_comb begin
        alu_f3    = ALU_ADD;
        alu_f3_ok = 1'b1;
        case (f3)
            3'b000:  alu_f3 = (state_q == EXEC_R && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_f3 = ALU_XOR;
            3'b110:  alu_f3 = ALU_OR;
            3'b111:  alu_f3 = ALU_AND;
            3'b010:  alu_f3 = ALU_SLT;
            default: alu_f3_ok = 1'b0;
        endcase
    end

    // Next-state and control outputs
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        immSrc     = IMM_I;
        fault      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end else if (wait_hit) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = (opc == OPC_JAL) ? IMM_J : IMM_B;
                case (opc)
                    OPC_R:            state_d = EXEC_R;
                    OPC_I:            state_d = EXEC_I;
                    OPC_LD, OPC_ST:   state_d = MEM_ADR;
                    OPC_BR:           state_d = BRANCH;
                    OPC_JAL:          state_d = JAL;
                    OPC_JALR:         state_d = JALR_A;
                    OPC_LUI:          state_d = LUI;
                    default:          state_d = FAULT;
                endcase
            end
            EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_f3;
                state_d    = alu_f3_ok ? ALU_WB : FAULT;
            end
            EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_f3;
                state_d    = alu_f3_ok ? ALU_WB : FAULT;
            end
            ALU_WB: begin
                regWrite = 1'b1;
                state_d  = FETCH;
            end
            MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immSrc  = (opc == OPC_ST) ? IMM_S : IMM_I;
                state_d = (opc == OPC_ST) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                adrSrc  = 1'b1;
                if (mem_ready)     state_d = MEM_WB;
                else if (wait_hit) state_d = FAULT;
            end
            MEM_WB: begin
                regWrite  = 1'b1;
                resultSrc = 2'b01;
                state_d   = FETCH;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (mem_ready)     state_d = FETCH;
                else if (wait_hit) state_d = FAULT;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                state_d    = FETCH;
                case (f3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = !zero;
                    3'b100:  PCWrite = neg;
                    3'b101:  PCWrite = !neg;
                    default: state_d = FAULT;
                endcase
            end
            JAL, JALR_L: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALU_WB;
            end
            JALR_A: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALR_L;
            end
            LUI: begin
                regWrite  = 1'b1;
                resultSrc = 2'b11;
                immSrc    = IMM_U;
                state_d   = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: state_d = FAULT;
        endcase
        // Reset forces every output low and aborts any access in flight
        if (rst) begin
            state_d    = FETCH;
            mem_req    = 1'b0;
            PCWrite    = 1'b0;
            adrSrc     = 1'b0;
            memWrite   = 1'b0;
            IRWrite    = 1'b0;
            regWrite   = 1'b0;
            resultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = ALU_ADD;
            immSrc     = IMM_I;
            fault      = 1'b0;
        end
    end

    // State register and wait counter; any state change starts a fresh wait window
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_q <= '0;
            else if (mem_req && !mem_ready)
                wait_q <= wait_q + WAIT_W'(1);
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Retirement is counted as any return to FETCH; FAULT never returns, so it freezes there
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state_q != FETCH && state_d == FETCH)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
